// File: rtl/paged_bcd_display_if.sv
// Bundles the display front-end's data, control and status signals.
// Latency: none, wiring only.
// Backpressure: none; load is a request that the front-end may ignore while busy or in hold.
interface paged_bcd_display_if #(
  parameter int DATA_W      = 36,
  parameter int PAGE_DIGITS = 3
);
  logic [DATA_W-1:0]        data_in;
  logic                     load;
  logic                     btn_n;
  logic                     blank_lz;
  logic [4*PAGE_DIGITS-1:0] hex_digit;
  logic [3:0]               page;
  logic                     running;
  logic                     busy;
  logic                     bcd_valid;

  // Source of the value and user controls; consumer of the display nibbles.
  modport master (
    output data_in, load, btn_n, blank_lz,
    input  hex_digit, page, running, busy, bcd_valid
  );

  // The display front-end itself.
  modport slave (
    input  data_in, load, btn_n, blank_lz,
    output hex_digit, page, running, busy, bcd_valid
  );
endinterface

// File: rtl/paged_bcd_display.sv
// Snapshots a binary value, converts it to BCD by shift-add-3 and pages the digits under a dwell timer.
// Latency: DATA_W cycles from accepted load to store update; hex_digit is one register behind store/page.
// Backpressure: load is dropped (not queued) while a conversion runs or while in hold.
module paged_bcd_display #(
  parameter int DATA_W      = 36,
  parameter int DIGITS      = 11,
  parameter int PAGE_DIGITS = 3,
  parameter int DWELL       = 25_000_000,
  parameter int DEBOUNCE    = 1_000_000
) (
  input  logic                 CLOCK_50,
  input  logic                 reset_n,
  paged_bcd_display_if.slave   bus
);

  localparam int PAGES   = (DIGITS + PAGE_DIGITS - 1) / PAGE_DIGITS;
  localparam int SLOTS   = PAGES * PAGE_DIGITS;
  localparam int BCD_W   = 4 * DIGITS;
  localparam int HEX_W   = 4 * PAGE_DIGITS;
  localparam int SC_W    = $clog2(DATA_W + 1);
  localparam int DB_W    = $clog2(DEBOUNCE + 1);
  localparam int DWELL_W = (DWELL > 1) ? $clog2(DWELL) : 1;

  typedef enum logic {
    ST_IDLE,
    ST_CONV
  } state_t;

  // Button synchroniser and debouncer state
  logic              sync1_q, sync1_d;
  logic              sync2_q, sync2_d;
  logic              deb_q, deb_d;
  logic              deb_prev_q, deb_prev_d;
  logic [DB_W-1:0]   deb_cnt_q, deb_cnt_d;
  logic              running_q, running_d;

  // Conversion engine state
  state_t            state_q, state_d;
  logic [SC_W-1:0]   shift_cnt_q, shift_cnt_d;
  logic [DATA_W-1:0] bin_q, bin_d;
  logic [BCD_W-1:0]  work_q, work_d;
  logic [BCD_W-1:0]  store_q, store_d;
  logic              busy_q, busy_d;
  logic              valid_q, valid_d;

  // Paging and display state
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [3:0]         page_q, page_d;
  logic [HEX_W-1:0]   hex_q, hex_d;

  // Combinational helpers for the display path
  logic [DIGITS-1:0]  lz;
  logic               seen_nz;
  logic [4*SLOTS-1:0] slot;
  logic [BCD_W-1:0]   adj;

  // Add 3 to every BCD digit that is 5 or more, ahead of the next left shift.
  function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] v);
    logic [BCD_W-1:0] r;
    r = v;
    for (int i = 0; i < DIGITS; i++) begin
      if (r[4*i +: 4] >= 4'd5) begin
        r[4*i +: 4] = r[4*i +: 4] + 4'd3;
      end
    end
    return r;
  endfunction

  // Button: two-stage synchroniser, stability counter, falling-edge toggle of run/hold.
  always_comb begin
    sync1_d    = bus.btn_n;
    sync2_d    = sync1_q;
    deb_d      = deb_q;
    deb_cnt_d  = deb_cnt_q;
    deb_prev_d = deb_q;
    if (sync2_q == deb_q) begin
      deb_cnt_d = '0;
    end else if (deb_cnt_q == DB_W'(DEBOUNCE)) begin
      deb_d     = sync2_q;
      deb_cnt_d = '0;
    end else begin
      deb_cnt_d = deb_cnt_q + 1'b1;
    end
    // A press is a debounced 1->0; release leaves running alone.
    running_d = running_q ^ (deb_prev_q & ~deb_q);
  end

  // Conversion: accept a snapshot when idle and running, then one shift per cycle MSB-first.
  always_comb begin
    state_d     = state_q;
    shift_cnt_d = shift_cnt_q;
    bin_d       = bin_q;
    work_d      = work_q;
    store_d     = store_q;
    busy_d      = busy_q;
    valid_d     = valid_q;
    adj         = add3(work_q);
    case (state_q)
      ST_IDLE: begin
        if (bus.load && running_q) begin
          state_d     = ST_CONV;
          busy_d      = 1'b1;
          bin_d       = bus.data_in;
          work_d      = '0;
          shift_cnt_d = '0;
        end
      end
      ST_CONV: begin
        work_d      = (adj << 1) | {{(BCD_W-1){1'b0}}, bin_q[DATA_W-1]};
        bin_d       = bin_q << 1;
        shift_cnt_d = shift_cnt_q + 1'b1;
        // The final shift lands straight in the store so the display never sees a partial value.
        if (shift_cnt_q == SC_W'(DATA_W - 1)) begin
          store_d = (adj << 1) | {{(BCD_W-1){1'b0}}, bin_q[DATA_W-1]};
          valid_d = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Paging: dwell timer runs only with a valid store and in run mode; pages step downwards and wrap.
  always_comb begin
    dwell_d = dwell_q;
    page_d  = page_q;
    if (running_q && valid_q) begin
      if (dwell_q == DWELL_W'(DWELL - 1)) begin
        dwell_d = '0;
        page_d  = (page_q == 4'd0) ? 4'(PAGES - 1) : page_q - 4'd1;
      end else begin
        dwell_d = dwell_q + 1'b1;
      end
    end
  end

  // Display: mark leading zeros, pad missing digits with blanks, pick the current page.
  always_comb begin
    seen_nz = 1'b0;
    lz      = '0;
    for (int j = DIGITS - 1; j >= 0; j--) begin
      lz[j]   = (store_q[4*j +: 4] == 4'd0) && !seen_nz && (j != 0);
      seen_nz = seen_nz | (store_q[4*j +: 4] != 4'd0);
    end
    slot = '1;
    for (int j = 0; j < DIGITS; j++) begin
      slot[4*j +: 4] = (bus.blank_lz && lz[j]) ? 4'hF : store_q[4*j +: 4];
    end
    hex_d = '1;
    if (valid_q) begin
      for (int p = 0; p < PAGES; p++) begin
        if (page_q == 4'(p)) begin
          hex_d = slot[HEX_W*p +: HEX_W];
        end
      end
    end
  end

  // All state registers, cleared asynchronously.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      deb_q       <= 1'b1;
      deb_prev_q  <= 1'b1;
      deb_cnt_q   <= '0;
      running_q   <= 1'b1;
      state_q     <= ST_IDLE;
      shift_cnt_q <= '0;
      bin_q       <= '0;
      work_q      <= '0;
      store_q     <= '0;
      busy_q      <= 1'b0;
      valid_q     <= 1'b0;
      dwell_q     <= '0;
      page_q      <= 4'(PAGES - 1);
      hex_q       <= '1;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      deb_q       <= deb_d;
      deb_prev_q  <= deb_prev_d;
      deb_cnt_q   <= deb_cnt_d;
      running_q   <= running_d;
      state_q     <= state_d;
      shift_cnt_q <= shift_cnt_d;
      bin_q       <= bin_d;
      work_q      <= work_d;
      store_q     <= store_d;
      busy_q      <= busy_d;
      valid_q     <= valid_d;
      dwell_q     <= dwell_d;
      page_q      <= page_d;
      hex_q       <= hex_d;
    end
  end

  assign bus.hex_digit = hex_q;
  assign bus.page      = page_q;
  assign bus.running   = running_q;
  assign bus.busy      = busy_q;
  assign bus.bcd_valid = valid_q;

endmodule

// File: tb/tb_paged_bcd_display.sv
// Randomised and directed bench for paged_bcd_display against a decimal-arithmetic model.
// Latency: model predicts every output each cycle.
// Backpressure: none.
module tb_paged_bcd_display;
  localparam int DATA_W      = 36;
  localparam int DIGITS      = 11;
  localparam int PAGE_DIGITS = 3;
  localparam int DWELL       = 4;
  localparam int DEBOUNCE    = 3;
  localparam int PAGES       = 4;

  logic CLOCK_50 = 1'b0;
  logic reset_n  = 1'b0;
  always #10 CLOCK_50 = ~CLOCK_50;

  paged_bcd_display_if #(.DATA_W(DATA_W), .PAGE_DIGITS(PAGE_DIGITS)) bus();

  paged_bcd_display #(
    .DATA_W(DATA_W), .DIGITS(DIGITS), .PAGE_DIGITS(PAGE_DIGITS),
    .DWELL(DWELL), .DEBOUNCE(DEBOUNCE)
  ) dut (
    .CLOCK_50(CLOCK_50),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int nvec = 0;
  int nmis = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected page nibbles from the decimal value, using plain division.
  function automatic logic [11:0] exp_hex(input longint unsigned v, input int pg,
                                          input bit blank, input bit valid);
    logic [11:0] r;
    longint unsigned t;
    int msd;
    int n;
    r = 12'hFFF;
    if (!valid) return r;
    msd = 0;
    t = v;
    for (int i = 0; i < DIGITS; i++) begin
      if (t % 10 != 0) msd = i;
      t = t / 10;
    end
    for (int k = 0; k < PAGE_DIGITS; k++) begin
      n = pg * PAGE_DIGITS + k;
      t = v;
      for (int i = 0; i < n; i++) t = t / 10;
      if (n < DIGITS && !(blank && n > msd)) r[4*k +: 4] = 4'(t % 10);
    end
    return r;
  endfunction

  // Reference model state
  bit              m_running = 1;
  bit              m_busy    = 0;
  bit              m_valid   = 0;
  int              m_page    = PAGES - 1;
  int              m_dwell   = 0;
  logic [11:0]     m_hex     = 12'hFFF;
  longint unsigned m_store   = 0;
  longint unsigned m_pend    = 0;
  int              m_rem     = 0;
  bit              m_deb     = 1;
  bit              m_fell    = 0;
  bit              bh [DEBOUNCE+2];

  // Model advance on each rising edge, then compare all outputs just after it.
  always @(posedge CLOCK_50) begin
    bit flip;
    bit ld, blk, b, rn;
    logic [DATA_W-1:0] dat;
    ld  = bus.load;
    blk = bus.blank_lz;
    b   = bus.btn_n;
    dat = bus.data_in;
    rn  = reset_n;
    if (!rn) begin
      m_running = 1; m_busy = 0; m_valid = 0; m_page = PAGES - 1; m_dwell = 0;
      m_hex = 12'hFFF; m_store = 0; m_rem = 0; m_deb = 1; m_fell = 0;
      for (int i = 0; i < DEBOUNCE + 2; i++) bh[i] = 1'b1;
    end else begin
      m_hex = exp_hex(m_store, m_page, blk, m_valid);
      if (m_running && m_valid) begin
        if (m_dwell == DWELL - 1) begin
          m_dwell = 0;
          m_page  = (m_page == 0) ? PAGES - 1 : m_page - 1;
        end else begin
          m_dwell++;
        end
      end
      if (m_busy) begin
        m_rem--;
        if (m_rem == 0) begin
          m_store = m_pend; m_valid = 1; m_busy = 0;
        end
      end else if (ld && m_running) begin
        m_busy = 1; m_pend = 64'(dat); m_rem = DATA_W;
      end
      // Debounced level flips once DEBOUNCE+1 consecutive synchronised samples disagree with it.
      flip = 1;
      for (int i = 1; i <= DEBOUNCE + 1; i++) if (bh[i] == m_deb) flip = 0;
      m_running = m_running ^ m_fell;
      m_fell    = flip && m_deb;
      if (flip) m_deb = !m_deb;
      for (int i = DEBOUNCE + 1; i >= 1; i--) bh[i] = bh[i-1];
      bh[0] = b;
    end
    #1;
    check("hex_digit", bus.hex_digit, m_hex);
    check("page",      bus.page, 64'(m_page));
    check("running",   bus.running, m_running);
    check("busy",      bus.busy, m_busy);
    check("bcd_valid", bus.bcd_valid, m_valid);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  task automatic do_load(input logic [DATA_W-1:0] v);
    @(negedge CLOCK_50);
    bus.data_in = v;
    bus.load    = 1'b1;
    @(negedge CLOCK_50);
    bus.load    = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while (bus.busy && t < 200) begin
      @(negedge CLOCK_50);
      t++;
    end
    check("busy_done", bus.busy, 0);
  endtask

  // Wait for a fresh entry into page p, then one more cycle for hex_digit, and check it.
  task automatic page_is(input int p, input logic [11:0] exp, input string name);
    int t = 0;
    while (bus.page == 4'(p) && t < 100) begin @(negedge CLOCK_50); t++; end
    while (bus.page != 4'(p) && t < 100) begin @(negedge CLOCK_50); t++; end
    check({name, "_page"}, bus.page, 64'(p));
    @(negedge CLOCK_50);
    check(name, bus.hex_digit, exp);
  endtask

  task automatic press(input int n);
    @(negedge CLOCK_50);
    bus.btn_n = 1'b0;
    tick(n);
    bus.btn_n = 1'b1;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    int pg_hold;
    logic [DATA_W-1:0] r;
    bus.data_in  = '0;
    bus.load     = 1'b0;
    bus.btn_n    = 1'b1;
    bus.blank_lz = 1'b0;
    reset_n      = 1'b0;
    tick(3);
    check("rst_hex", bus.hex_digit, 12'hFFF);
    check("rst_page", bus.page, 3);
    check("rst_running", bus.running, 1);
    check("rst_busy", bus.busy, 0);
    check("rst_valid", bus.bcd_valid, 0);
    reset_n = 1'b1;
    tick(2);

    // Eleven-digit value across all four pages
    do_load(36'd12345678901);
    cnt = 0;
    while (bus.busy && cnt < 100) begin cnt++; @(negedge CLOCK_50); end
    check("busy_cycles", 64'(cnt), 36);
    check("valid_set", bus.bcd_valid, 1);
    page_is(2, 12'h345, "p2_345");
    page_is(1, 12'h678, "p1_678");
    page_is(0, 12'h901, "p0_901");
    page_is(3, 12'hF12, "p3_F12");

    // Small value with and without leading-zero blanking
    bus.blank_lz = 1'b1;
    do_load(36'd42);
    wait_idle();
    page_is(3, 12'hFFF, "lz_p3");
    page_is(2, 12'hFFF, "lz_p2");
    page_is(1, 12'hFFF, "lz_p1");
    page_is(0, 12'hF42, "lz_p0");
    bus.blank_lz = 1'b0;
    page_is(3, 12'hF00, "nolz_p3");
    page_is(0, 12'h042, "nolz_p0");
    bus.blank_lz = 1'b1;
    do_load(36'd0);
    wait_idle();
    page_is(0, 12'hFF0, "zero_p0");

    // Button: glitch, hold, resume
    press(2);
    tick(10);
    check("glitch_running", bus.running, 1);
    press(10);
    tick(10);
    check("hold_running", bus.running, 0);
    pg_hold = m_page;
    do_load(36'd999);
    tick(3);
    check("hold_load_busy", bus.busy, 0);
    tick(17);
    check("hold_page", bus.page, 64'(pg_hold));
    press(10);
    tick(10);
    check("resume_running", bus.running, 1);

    // Second load while busy is dropped
    do_load(36'd111);
    tick(5);
    do_load(36'd222);
    wait_idle();
    page_is(0, 12'h111, "first_wins");

    // Reset in the middle of a conversion
    do_load(36'd987654321);
    tick(19);
    check("mid_busy", bus.busy, 1);
    reset_n = 1'b0;
    #1;
    check("arst_busy", bus.busy, 0);
    check("arst_valid", bus.bcd_valid, 0);
    check("arst_hex", bus.hex_digit, 12'hFFF);
    @(negedge CLOCK_50);
    @(negedge CLOCK_50);
    reset_n = 1'b1;
    tick(2);

    // Full-scale input
    bus.blank_lz = 1'b1;
    do_load({DATA_W{1'b1}});
    wait_idle();
    page_is(0, 12'h735, "max_p0");
    page_is(3, 12'hF68, "max_p3");

    // Random traffic checked cycle by cycle against the model
    for (int it = 0; it < 500; it++) begin
      case ($urandom_range(0, 9))
        0, 1: begin
          r = 36'({$urandom(), $urandom()});
          do_load(r);
        end
        2, 3: do_load(36'($urandom_range(0, 9999)));
        4:    bus.blank_lz = 1'($urandom_range(0, 1));
        5:    press($urandom_range(1, 8));
        default: tick($urandom_range(1, 6));
      endcase
    end
    tick(60);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
